// File: rtl/envelope_voice_sequencer.sv
// Per-voice envelope sequencer: velocity bank plus a tick-driven scan that feeds the envelope calculator.
// Optional define SUSTAIN_PEDAL_EN defers note releases while the sustain pedal is held.
module envelope_voice_sequencer #(
  parameter int NUM_VOICES = 4,
  parameter int TICK_DIV   = 50000,
  localparam int VW        = $clog2(NUM_VOICES)
) (
  input  logic                    clk,
  input  logic                    nrst,
  input  logic                    en,
  input  logic                    note_on,
  input  logic                    note_off,
  input  logic [VW-1:0]           note_voice,
  input  logic [6:0]              note_velocity,
  input  logic                    sustain,
  input  logic [6:0]              single_new_note_velocity,
  output logic                    envelope_pulse,
  output logic                    poly_start,
  output logic [6:0]              velocity_sel,
  output logic                    key_pressed,
  output logic                    ended_note,
  output logic [7*NUM_VOICES-1:0] voice_velocity,
  output logic [NUM_VOICES-1:0]   voice_active,
  output logic                    frame_done
);

  localparam int            CW       = $clog2(TICK_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);
  localparam logic [VW-1:0] IDX_LAST = VW'(NUM_VOICES - 1);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_t;

  state_t          state, state_d;
  logic [VW-1:0]   idx, idx_d;
  logic            tick_pending, tick_pending_d;
  logic [CW-1:0]   cnt;
  logic            tick;
  logic            scan_wr;

  logic [6:0]            vel [NUM_VOICES];
  logic [NUM_VOICES-1:0] held;
  logic [NUM_VOICES-1:0] ended;

  assign tick    = en && (cnt == CNT_LAST);
  assign scan_wr = (state == SCAN);

  always_ff @(posedge clk) begin
    if (!nrst) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == CNT_LAST) ? '0 : cnt + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state        <= IDLE;
      idx          <= '0;
      tick_pending <= 1'b0;
    end else begin
      state        <= state_d;
      idx          <= idx_d;
      tick_pending <= tick_pending_d;
    end
  end

  // NOTE: every output of a combinational block gets a default first so no path can infer a latch.
  always_comb begin
    state_d        = state;
    idx_d          = idx;
    tick_pending_d = tick_pending;
    if (tick && state != IDLE) tick_pending_d = 1'b1;
    case (state)
      IDLE: begin
        if (tick || tick_pending) begin
          state_d        = SCAN;
          idx_d          = '0;
          tick_pending_d = 1'b0;
        end
      end
      SCAN: begin
        if (idx == IDX_LAST) state_d = DONE;
        else                 idx_d   = idx + VW'(1);
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    envelope_pulse = 1'b0;
    poly_start     = 1'b0;
    velocity_sel   = '0;
    key_pressed    = 1'b0;
    ended_note     = 1'b0;
    frame_done     = (state == DONE);
    if (state == SCAN) begin
      envelope_pulse = 1'b1;
      velocity_sel   = vel[idx];
      poly_start     = (vel[idx] != '0);
      key_pressed    = held[idx];
      ended_note     = ended[idx];
    end
  end

`ifdef SUSTAIN_PEDAL_EN
  logic                  sustain_q;
  logic                  sustain_fall;
  logic [NUM_VOICES-1:0] rel_pend;

  assign sustain_fall = sustain_q && !sustain;

  always_ff @(posedge clk) begin
    if (!nrst) sustain_q <= 1'b0;
    else       sustain_q <= sustain;
  end
`else
  logic unused_sustain;
  assign unused_sustain = sustain;
`endif

  // Priority, lowest to highest: scan writeback, sustain release, note events.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      // NOTE: the velocity bank is small and the mixer reads it directly, so it is reset like any other state.
      for (int i = 0; i < NUM_VOICES; i++) vel[i] <= '0;
      held  <= '0;
      ended <= '0;
`ifdef SUSTAIN_PEDAL_EN
      rel_pend <= '0;
`endif
    end else begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        // NOTE: non-blocking assignments; a later assignment to the same bit in this block overrides an earlier one.
        if (scan_wr && idx == VW'(i)) begin
          vel[i] <= single_new_note_velocity;
          if (single_new_note_velocity == '0) ended[i] <= 1'b0;
        end
`ifdef SUSTAIN_PEDAL_EN
        if (sustain_fall && rel_pend[i]) begin
          ended[i]    <= 1'b1;
          rel_pend[i] <= 1'b0;
        end
`endif
        if (note_on && note_voice == VW'(i)) begin
          vel[i]   <= note_velocity;
          held[i]  <= 1'b1;
          ended[i] <= 1'b0;
`ifdef SUSTAIN_PEDAL_EN
          rel_pend[i] <= 1'b0;
`endif
        end else if (note_off && note_voice == VW'(i) && vel[i] != '0) begin
          held[i] <= 1'b0;
`ifdef SUSTAIN_PEDAL_EN
          if (sustain) rel_pend[i] <= 1'b1;
          else         ended[i]    <= 1'b1;
`else
          ended[i] <= 1'b1;
`endif
        end
      end
    end
  end

  always_comb begin
    voice_velocity = '0;
    voice_active   = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      voice_velocity[7*i +: 7] = vel[i];
      voice_active[i]          = (vel[i] != '0);
    end
  end

endmodule

// File: tb/tb_envelope_voice_sequencer.sv
// Directed bench for envelope_voice_sequencer with a small envelope-calculator model.
module tb_envelope_voice_sequencer;

  localparam int NV = 4;
  localparam int TD = 6;
`ifdef SUSTAIN_PEDAL_EN
  localparam bit SUS = 1'b1;
`else
  localparam bit SUS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        nrst, en, note_on, note_off, sustain;
  logic [1:0]  note_voice;
  logic [6:0]  note_velocity;
  logic [6:0]  calc;
  logic        envelope_pulse, poly_start, key_pressed, ended_note, frame_done;
  logic [6:0]  velocity_sel;
  logic [27:0] voice_velocity;
  logic [3:0]  voice_active;

  logic        force_en  = 1'b0;
  logic [6:0]  force_val = 7'd5;

  int n_checks   = 0;
  int n_fail     = 0;
  int cyc        = 0;
  int last_start = 0;
  int prev_start = 0;

  envelope_voice_sequencer #(.NUM_VOICES(NV), .TICK_DIV(TD)) dut (
    .clk                      (clk),
    .nrst                     (nrst),
    .en                       (en),
    .note_on                  (note_on),
    .note_off                 (note_off),
    .note_voice               (note_voice),
    .note_velocity            (note_velocity),
    .sustain                  (sustain),
    .single_new_note_velocity (calc),
    .envelope_pulse           (envelope_pulse),
    .poly_start               (poly_start),
    .velocity_sel             (velocity_sel),
    .key_pressed              (key_pressed),
    .ended_note               (ended_note),
    .voice_velocity           (voice_velocity),
    .voice_active             (voice_active),
    .frame_done               (frame_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Calculator model: held voices decay by 1, released voices by 15, others hold.
  always_comb begin
    calc = velocity_sel;
    if (force_en)          calc = force_val;
    else if (key_pressed)  calc = (velocity_sel == 7'd0) ? 7'd0 : 7'(velocity_sel - 7'd1);
    else if (ended_note)   calc = (velocity_sel > 7'd15) ? 7'(velocity_sel - 7'd15) : 7'd0;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic note(input bit on, input int v, input int velo);
    note_on       = on;
    note_off      = !on;
    note_voice    = 2'(v);
    note_velocity = 7'(velo);
    step();
    note_on  = 1'b0;
    note_off = 1'b0;
  endtask

  function automatic logic [27:0] pk(input int a3, input int a2, input int a1, input int a0);
    return {7'(a3), 7'(a2), 7'(a1), 7'(a0)};
  endfunction

  // Waits for a scan, records the calculator-facing outputs per index and checks the frame pulse.
  task automatic run_scan(input string tag, input logic [3:0] ep, input logic [3:0] ek,
                          input logic [3:0] ee, input logic [27:0] es, input bit collide);
    logic [3:0]  gp, gk, ge;
    logic [27:0] gs;
    int          pulses, waited;
    waited = 0;
    while (envelope_pulse !== 1'b1 && waited < 40) begin
      step();
      waited++;
    end
    if (envelope_pulse !== 1'b1) begin
      check({tag, "_timeout"}, 32'(envelope_pulse), 32'd1);
      return;
    end
    prev_start = last_start;
    last_start = cyc;
    pulses = 0;
    for (int i = 0; i < NV; i++) begin
      gp[i]       = poly_start;
      gk[i]       = key_pressed;
      ge[i]       = ended_note;
      gs[7*i +: 7] = velocity_sel;
      pulses      += int'(envelope_pulse);
      if (collide && i == 0) begin
        note_on       = 1'b1;
        note_voice    = 2'd0;
        note_velocity = 7'd90;
        force_en      = 1'b1;
      end
      step();
      note_on  = 1'b0;
      force_en = 1'b0;
    end
    check({tag, "_poly"},   32'(gp), 32'(ep));
    check({tag, "_key"},    32'(gk), 32'(ek));
    check({tag, "_ended"},  32'(ge), 32'(ee));
    check({tag, "_sel"},    32'(gs), 32'(es));
    check({tag, "_pulses"}, 32'(pulses), 32'(NV));
    check({tag, "_done"},   {30'd0, frame_done, envelope_pulse}, 32'b10);
    step();
    check({tag, "_done_end"}, 32'(frame_done), 32'd0);
  endtask

  initial begin
    nrst = 1'b0; en = 1'b1; sustain = 1'b0;
    note_on = 1'b1; note_off = 1'b0; note_voice = 2'd2; note_velocity = 7'd100;

    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_ctl", {27'd0, envelope_pulse, poly_start, key_pressed, ended_note, frame_done}, 32'd0);
      check("rst_sel", 32'(velocity_sel), 32'd0);
      check("rst_vv",  32'(voice_velocity), 32'd0);
      check("rst_act", 32'(voice_active), 32'd0);
    end
    nrst = 1'b1;
    note_on = 1'b0;

    for (int i = 1; i < TD; i++) begin
      step();
      check("idle_quiet", {30'd0, envelope_pulse, frame_done}, 32'd0);
      if (i == 1) begin
        note_on = 1'b1; note_voice = 2'd2; note_velocity = 7'd100;
      end else begin
        note_on = 1'b0;
      end
    end
    check("note_on_v2",  32'(voice_velocity[20:14]), 32'd100);
    check("note_on_act", 32'(voice_active), 32'b0100);

    run_scan("scan1", 4'b0100, 4'b0100, 4'b0000, pk(0, 100, 0, 0), 1'b0);
    en = 1'b0;
    check("scan1_v2", 32'(voice_velocity[20:14]), 32'd99);
    en = 1'b1;
    run_scan("scan2", 4'b0100, 4'b0100, 4'b0000, pk(0, 99, 0, 0), 1'b0);
    en = 1'b0;
    check("scan2_v2", 32'(voice_velocity[20:14]), 32'd98);

    note(1'b1, 1, 40);
    note(1'b0, 1, 0);
    en = 1'b1;
    run_scan("scan3", 4'b0110, 4'b0100, 4'b0010, pk(0, 98, 40, 0), 1'b0);
    en = 1'b0;
    check("decay_v1_a", 32'(voice_velocity[13:7]), 32'd25);
    en = 1'b1;
    run_scan("scan4", 4'b0110, 4'b0100, 4'b0010, pk(0, 97, 25, 0), 1'b0);
    en = 1'b0;
    check("decay_v1_b", 32'(voice_velocity[13:7]), 32'd10);
    en = 1'b1;
    run_scan("scan5", 4'b0110, 4'b0100, 4'b0010, pk(0, 96, 10, 0), 1'b0);
    en = 1'b0;
    check("decay_v1_c",   32'(voice_velocity[13:7]), 32'd0);
    check("decay_active", 32'(voice_active), 32'b0100);
    en = 1'b1;
    run_scan("scan6", 4'b0100, 4'b0100, 4'b0000, pk(0, 95, 0, 0), 1'b0);
    en = 1'b0;

    en = 1'b1;
    run_scan("scan7", 4'b0100, 4'b0100, 4'b0000, pk(0, 94, 0, 0), 1'b1);
    en = 1'b0;
    check("collide_vv",  32'(voice_velocity), 32'(pk(0, 93, 0, 90)));
    check("collide_act", 32'(voice_active), 32'b0101);

    en = 1'b1;
    run_scan("scan8",  4'b0101, 4'b0101, 4'b0000, pk(0, 93, 0, 90), 1'b0);
    run_scan("scan9",  4'b0101, 4'b0101, 4'b0000, pk(0, 92, 0, 89), 1'b0);
    check("overrun_period_a", 32'(last_start - prev_start), 32'(TD));
    run_scan("scan10", 4'b0101, 4'b0101, 4'b0000, pk(0, 91, 0, 88), 1'b0);
    check("overrun_period_b", 32'(last_start - prev_start), 32'(TD));
    en = 1'b0;

    note(1'b0, 1, 0);
    note(1'b1, 3, 60);
    sustain = 1'b1;
    note(1'b0, 3, 0);
    en = 1'b1;
    run_scan("scan11", 4'b1101, 4'b0101, SUS ? 4'b0000 : 4'b1000, pk(60, 90, 0, 87), 1'b0);
    en = 1'b0;
    sustain = 1'b0;
    step();
    en = 1'b1;
    run_scan("scan12", 4'b1101, 4'b0101, 4'b1000, pk(SUS ? 60 : 45, 89, 0, 86), 1'b0);
    en = 1'b0;
    check("sustain_v3", 32'(voice_velocity[27:21]), SUS ? 32'd45 : 32'd30);

    en = 1'b1;
    for (int i = 0; i < 20 && envelope_pulse !== 1'b1; i++) step();
    check("midscan_start", 32'(envelope_pulse), 32'd1);
    step();
    nrst = 1'b0;
    step();
    check("midscan_ctl", {30'd0, envelope_pulse, frame_done}, 32'd0);
    check("midscan_vv",  32'(voice_velocity), 32'd0);
    nrst = 1'b1;
    en = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
